// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Data accesses win ties; a global stall holds the pipeline until every pending request is served.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          stall,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t        state;
  logic [CW-1:0] tcnt;
  logic          if_done;
  logic          d_done;
  logic          busy_load;
  logic          d_pend;
  logic          timed_out;

  // Handshake: a requester holds its request stable while stall=1; the matching
  // x_valid pulse marks the cycle in which the registered rdata may be sampled,
  // and stall falls in that same cycle once nothing else is outstanding.
  assign d_pend    = d_read | d_write;
  assign stall     = (d_pend & ~d_done & ~d_valid) | (if_req & ~if_done & ~if_valid);
  assign timed_out = (TIMEOUT > 0) && (tcnt == CNT_LAST);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      busy_load <= 1'b0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      // Pipeline advances: forget what was served so the next request is fresh.
      if (!stall) begin
        if_done <= 1'b0;
        d_done  <= 1'b0;
      end
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (d_pend && !d_done) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            busy_load <= ~d_write;
          end else if (if_req && !if_done) begin
            state    <= BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack || timed_out) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (!mem_ack) err <= 1'b1;
            if (state == BUSY_I) begin
              if_valid <= 1'b1;
              if_done  <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_valid <= 1'b1;
              d_done  <= 1'b1;
              // An aborted access returns zero; a completed store keeps the old load data.
              if (!mem_ack)       d_rdata <= '0;
              else if (busy_load) d_rdata <= mem_rdata;
            end
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a short random phase,
// with per-port expected-data queues popped on each valid pulse.
module tb_mem_port_arbiter;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];

  int          mem_lat  = 1;
  bit          late_ack = 1'b0;
  int          busy_cnt = 0;
  int          acc_cnt  = 0;
  logic [31:0] last_wdata = '0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall(stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'h2002_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    if_req  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  // memory model: ack after mem_lat request cycles (0 = never)
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (!mem_req) busy_cnt = 0;
      if (late_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end else if (mem_req) begin
        busy_cnt++;
        if (mem_lat != 0 && busy_cnt == mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 32'h0 : rd(mem_addr);
          acc_cnt++;
          if (mem_we) last_wdata = mem_wdata;
        end
      end
    end
  end

  // scoreboard: each valid pulse pops one expected rdata
  initial begin
    forever begin
      @(negedge clk);
      if (if_valid) begin
        if (if_exp_q.size() == 0) check("if_valid_spurious", if_valid, 0);
        else check("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (d_valid) begin
        if (d_exp_q.size() == 0) check("d_valid_spurious", d_valid, 0);
        else check("d_rdata", d_rdata, d_exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; drop_all();
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_valids", {if_valid, d_valid}, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall, 0);
    next_cyc(); rst = 1'b0;
    next_cyc();

    // fetch only
    if_req = 1'b1; if_addr = 32'h4; if_exp_q.push_back(rd(32'h4));
    @(negedge clk);
    check("t1_stall_c0", stall, 1);
    check("t1_mem_req_c0", mem_req, 0);
    next_cyc(); @(negedge clk);
    check("t1_mem_req_c1", mem_req, 1);
    check("t1_mem_addr", mem_addr, 32'h4);
    check("t1_mem_we", mem_we, 0);
    check("t1_stall_c1", stall, 1);
    next_cyc(); @(negedge clk);
    check("t1_if_valid_c2", if_valid, 1);
    check("t1_stall_c2", stall, 0);
    next_cyc(); drop_all();
    next_cyc();

    // load and fetch together
    begin
      int acc0;
      acc0 = acc_cnt;
      d_read = 1'b1; d_addr = 32'h10; if_req = 1'b1; if_addr = 32'h8;
      d_exp_q.push_back(rd(32'h10)); if_exp_q.push_back(rd(32'h8));
      @(negedge clk);
      check("t2_stall_c0", stall, 1);
      next_cyc(); @(negedge clk);
      check("t2_mem_addr_d", mem_addr, 32'h10);
      check("t2_mem_we_d", mem_we, 0);
      check("t2_stall_c1", stall, 1);
      next_cyc(); @(negedge clk);
      check("t2_d_valid_c2", d_valid, 1);
      check("t2_if_valid_c2", if_valid, 0);
      check("t2_stall_c2", stall, 1);
      check("t2_mem_req_c2", mem_req, 0);
      next_cyc(); @(negedge clk);
      check("t2_mem_req_c3", mem_req, 1);
      check("t2_mem_addr_i", mem_addr, 32'h8);
      check("t2_stall_c3", stall, 1);
      next_cyc(); @(negedge clk);
      check("t2_if_valid_c4", if_valid, 1);
      check("t2_d_valid_c4", d_valid, 0);
      check("t2_stall_c4", stall, 0);
      next_cyc(); drop_all();
      next_cyc(); @(negedge clk);
      check("t2_access_count", acc_cnt - acc0, 2);
      mem_lat = 3;
    end

    // store
    next_cyc();
    d_write = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D;
    d_exp_q.push_back(rd(32'h10));
    for (int k = 1; k <= 3; k++) begin
      next_cyc(); @(negedge clk);
      check("t3_mem_req", mem_req, 1);
      check("t3_mem_we", mem_we, 1);
      check("t3_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      check("t3_mem_addr", mem_addr, 32'h20);
      check("t3_stall", stall, 1);
    end
    next_cyc(); @(negedge clk);
    check("t3_d_valid", d_valid, 1);
    check("t3_stall_end", stall, 0);
    check("t3_written", last_wdata, 32'hCAFE_F00D);
    next_cyc(); drop_all();
    next_cyc(); @(negedge clk);
    check("t3_single_pulse", d_valid, 0);
    mem_lat = 5;

    // slow memory
    next_cyc();
    if_req = 1'b1; if_addr = 32'h40; if_exp_q.push_back(rd(32'h40));
    for (int k = 1; k <= 5; k++) begin
      next_cyc(); @(negedge clk);
      check("t4_mem_req", mem_req, 1);
      check("t4_mem_addr", mem_addr, 32'h40);
      check("t4_stall", stall, 1);
    end
    next_cyc(); @(negedge clk);
    check("t4_if_valid", if_valid, 1);
    check("t4_stall_end", stall, 0);
    check("t4_err", err, 0);
    next_cyc(); drop_all();
    next_cyc(); @(negedge clk);
    mem_lat = 0;

    // timeout with no ack, then a late ack while idle
    next_cyc();
    d_read = 1'b1; d_addr = 32'h80; d_exp_q.push_back(32'h0);
    for (int k = 1; k <= TO; k++) begin
      next_cyc(); @(negedge clk);
      check("t5_mem_req", mem_req, 1);
      check("t5_err_before", err, 0);
    end
    next_cyc(); @(negedge clk);
    check("t5_mem_req_drop", mem_req, 0);
    check("t5_err", err, 1);
    check("t5_d_valid", d_valid, 1);
    check("t5_stall_end", stall, 0);
    late_ack = 1'b1;
    next_cyc(); drop_all();
    @(negedge clk);
    late_ack = 1'b0;
    check("t5_no_valid_c8", d_valid, 0);
    next_cyc(); @(negedge clk);
    check("t5_late_d_valid", d_valid, 0);
    check("t5_late_if_valid", if_valid, 0);
    check("t5_late_d_rdata", d_rdata, 0);
    check("t5_late_mem_req", mem_req, 0);
    check("t5_late_state", dbg_state, 0);
    check("t5_err_sticky", err, 1);

    // reset during BUSY, then the held fetch is granted normally
    next_cyc();
    if_req = 1'b1; if_addr = 32'h100;
    next_cyc(); @(negedge clk);
    check("t6_busy1", mem_req, 1);
    next_cyc(); rst = 1'b1;
    @(negedge clk);
    check("t6_busy2", mem_req, 1);
    next_cyc(); @(negedge clk);
    check("t6_rst_mem_req", mem_req, 0);
    check("t6_rst_state", dbg_state, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_if_valid", if_valid, 0);
    check("t6_rst_if_rdata", if_rdata, 0);
    check("t6_rst_mem_addr", mem_addr, 0);
    mem_lat = 1;
    next_cyc(); rst = 1'b0; if_exp_q.push_back(rd(32'h100));
    @(negedge clk);
    check("t6_idle_after_rst", mem_req, 0);
    next_cyc(); @(negedge clk);
    check("t6_regrant", mem_req, 1);
    check("t6_regrant_addr", mem_addr, 32'h100);
    next_cyc(); @(negedge clk);
    check("t6_if_valid", if_valid, 1);
    check("t6_stall_end", stall, 0);
    next_cyc(); drop_all();
    next_cyc(); @(negedge clk);

    // random fetch / load mixes
    for (int it = 0; it < 12; it++) begin
      int          kind;
      logic [31:0] ia;
      logic [31:0] da;
      kind = $urandom_range(0, 2);
      ia   = 32'($urandom_range(0, 1023)) << 2;
      da   = 32'($urandom_range(0, 1023)) << 2;
      mem_lat = $urandom_range(1, 4);
      next_cyc();
      if (kind != 1) begin
        if_req = 1'b1; if_addr = ia; if_exp_q.push_back(rd(ia));
      end
      if (kind != 0) begin
        d_read = 1'b1; d_addr = da; d_exp_q.push_back(rd(da));
      end
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (!stall) break;
      end
      check("rand_stall_release", stall, 0);
      next_cyc(); drop_all();
      next_cyc(); @(negedge clk);
    end

    check("if_queue_drained", if_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);
    check("final_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
